// File: rtl/disp_page_arbiter.sv
// Round-robin page arbiter sharing one 4-digit hex display among N_REQ requesters, with a minimum page dwell.
// Optional idle auto-scroll through pages is enabled by defining DISP_PAGE_AUTO_SCROLL_EN.
module disp_page_arbiter #(
  parameter int N_REQ    = 4,
  parameter int HOLD_CNT = 25000000,
  parameter int CNT_W    = 25,
  parameter int IDX_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [16*N_REQ-1:0]    data,
  input  logic [4*N_REQ-1:0]     dp,
  output logic [3:0]             hex3,
  output logic [3:0]             hex2,
  output logic [3:0]             hex1,
  output logic [3:0]             hex0,
  output logic [3:0]             dp_out,
  output logic [N_REQ-1:0]       grant,
  output logic [IDX_W-1:0]       page_idx,
  output logic                   active,
  output logic                   hold_busy
);

  typedef enum logic [1:0] {IDLE, HOLD, DWELL} state_t;

  state_t             state;
  logic [N_REQ-1:0]   pending;
  logic [IDX_W-1:0]   last;
  logic [CNT_W-1:0]   cnt;

  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [IDX_W-1:0]   nxt_idx;
  logic [IDX_W-1:0]   go_idx;
  logic [N_REQ-1:0]   go_onehot;
  logic               hold_done;
  logic               scroll_go;
  logic               go;
  logic [15:0]        sel_dat;
  logic [3:0]         sel_dp;

  // Scan starts just after the last granted index and wraps around.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = last;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == IDX_W'(N_REQ-1)) ? '0 : cand + 1'b1;
      if (!win_vld && pending[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign nxt_idx   = (last == IDX_W'(N_REQ-1)) ? '0 : last + 1'b1;
  assign hold_done = (state == HOLD) && (cnt == CNT_W'(HOLD_CNT-1));

`ifdef DISP_PAGE_AUTO_SCROLL_EN
  logic [CNT_W-1:0] scnt;

  assign scroll_go = (state != HOLD) && !win_vld && (scnt == CNT_W'(HOLD_CNT-1));

  always_ff @(posedge clk) begin
    if (reset)
      scnt <= '0;
    else if (go || win_vld || state == HOLD)
      scnt <= '0;
    else
      scnt <= scnt + 1'b1;
  end
`else
  assign scroll_go = 1'b0;
`endif

  // A pending request at the last hold cycle re-grants immediately, so pages are exactly HOLD_CNT long.
  assign go     = (win_vld && (state != HOLD || hold_done)) || scroll_go;
  assign go_idx = win_vld ? win_idx : nxt_idx;

  always_comb begin
    go_onehot = '0;
    for (int i = 0; i < N_REQ; i++)
      go_onehot[i] = (go_idx == IDX_W'(i));
  end

  always_comb begin
    sel_dat = '0;
    sel_dp  = 4'b1111;
    for (int i = 0; i < N_REQ; i++) begin
      if (page_idx == IDX_W'(i)) begin
        sel_dat = data[16*i +: 16];
        sel_dp  = dp[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      last      <= IDX_W'(N_REQ-1);
      cnt       <= '0;
      grant     <= '0;
      page_idx  <= '0;
      active    <= 1'b0;
      hold_busy <= 1'b0;
      hex3      <= '0;
      hex2      <= '0;
      hex1      <= '0;
      hex0      <= '0;
      dp_out    <= 4'b1111;
    end else begin
      // Set wins over clear: a requester still asserting req stays pending after its grant.
      pending <= (pending & ~(go ? go_onehot : '0)) | req;

      if (active) begin
        {hex3, hex2, hex1, hex0} <= sel_dat;
        dp_out                   <= sel_dp;
      end

      if (go) begin
        grant     <= go_onehot;
        page_idx  <= go_idx;
        last      <= go_idx;
        active    <= 1'b1;
        cnt       <= '0;
        hold_busy <= 1'b1;
        state     <= HOLD;
      end else if (hold_done) begin
        hold_busy <= 1'b0;
        state     <= DWELL;
      end else if (state == HOLD) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_page_arbiter.sv
// Directed self-checking bench for disp_page_arbiter with HOLD_CNT=8, N_REQ=4.
module tb_disp_page_arbiter;

  localparam int N_REQ = 4;
  localparam int HOLD  = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_REQ-1:0]     req;
  logic [16*N_REQ-1:0]  data;
  logic [4*N_REQ-1:0]   dp;
  logic [3:0]           hex3, hex2, hex1, hex0, dp_out;
  logic [N_REQ-1:0]     grant;
  logic [1:0]           page_idx;
  logic                 active, hold_busy;
  logic [15:0]          hex_all;

  int checks = 0;
  int passes = 0;

  assign hex_all = {hex3, hex2, hex1, hex0};

  always #5 clk = ~clk;

  disp_page_arbiter #(.N_REQ(N_REQ), .HOLD_CNT(HOLD), .CNT_W(4), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .dp(dp),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_out(dp_out),
    .grant(grant), .page_idx(page_idx), .active(active), .hold_busy(hold_busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 4'b0000) $display("FAIL rst_grant: got %b expected 0000", grant); else passes++;
    checks++; if (active !== 1'b0) $display("FAIL rst_active: got %b expected 0", active); else passes++;
    checks++; if (hold_busy !== 1'b0) $display("FAIL rst_hold_busy: got %b expected 0", hold_busy); else passes++;
    checks++; if (dp_out !== 4'b1111) $display("FAIL rst_dp_out: got %b expected 1111", dp_out); else passes++;
    checks++; if (hex_all !== 16'h0000) $display("FAIL rst_hex: got %h expected 0000", hex_all); else passes++;
    checks++; if (page_idx !== 2'd0) $display("FAIL rst_page_idx: got %0d expected 0", page_idx); else passes++;
  endtask

  task automatic test_single();
    int hb;
    do_reset();
    req = 4'b0100;
    tick();
    req = '0;
    checks++; if (grant !== 4'b0000) $display("FAIL single_early: got %b expected 0000", grant); else passes++;
    tick();
    checks++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", grant); else passes++;
    checks++; if (page_idx !== 2'd2) $display("FAIL single_idx: got %0d expected 2", page_idx); else passes++;
    checks++; if (active !== 1'b1) $display("FAIL single_active: got %b expected 1", active); else passes++;
    hb = hold_busy ? 1 : 0;
    tick();
    checks++; if (hex_all !== 16'h3333) $display("FAIL single_hex: got %h expected 3333", hex_all); else passes++;
    checks++; if (dp_out !== 4'b1011) $display("FAIL single_dp: got %b expected 1011", dp_out); else passes++;
    if (hold_busy) hb++;
    repeat (14) begin
      tick();
      if (hold_busy) hb++;
    end
    checks++; if (hb !== HOLD) $display("FAIL single_hold_len: got %0d cycles expected %0d", hb, HOLD); else passes++;
`ifndef DISP_PAGE_AUTO_SCROLL_EN
    checks++; if (grant !== 4'b0100) $display("FAIL single_stays: got %b expected 0100", grant); else passes++;
`endif
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 4'b1011;
    tick();
    req = '0;
    tick();
    checks++; if (grant !== 4'b0001) $display("FAIL simul_g0: got %b expected 0001", grant); else passes++;
    repeat (7) tick();
    checks++; if (grant !== 4'b0001) $display("FAIL simul_g0_held: got %b expected 0001", grant); else passes++;
    tick();
    checks++; if (grant !== 4'b0010) $display("FAIL simul_g1: got %b expected 0010", grant); else passes++;
    repeat (7) tick();
    tick();
    checks++; if (grant !== 4'b1000) $display("FAIL simul_g3: got %b expected 1000", grant); else passes++;
    checks++; if (page_idx !== 2'd3) $display("FAIL simul_idx3: got %0d expected 3", page_idx); else passes++;
    repeat (7) tick();
    checks++; if (hold_busy !== 1'b1) $display("FAIL simul_hb_last: got %b expected 1", hold_busy); else passes++;
    tick();
    checks++; if (hold_busy !== 1'b0) $display("FAIL simul_hb_end: got %b expected 0", hold_busy); else passes++;
    checks++; if (grant !== 4'b1000) $display("FAIL simul_dwell: got %b expected 1000", grant); else passes++;
  endtask

  task automatic test_hold_request();
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    repeat (3) tick();
    req = 4'b0010;
    tick();
    req = '0;
    checks++; if (grant !== 4'b0001) $display("FAIL hreq_no_preempt: got %b expected 0001", grant); else passes++;
    repeat (3) tick();
    checks++; if (grant !== 4'b0001) $display("FAIL hreq_hold_end: got %b expected 0001", grant); else passes++;
    tick();
    checks++; if (grant !== 4'b0010) $display("FAIL hreq_g1: got %b expected 0010", grant); else passes++;
  endtask

  task automatic test_level();
    logic [3:0] exp_g [4];
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0001; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
    do_reset();
    req = 4'b1000;
    tick();
    tick();
    for (int p = 0; p < 4; p++) begin
      checks++; if (grant !== exp_g[p]) $display("FAIL level_start%0d: got %b expected %b", p, grant, exp_g[p]); else passes++;
      tick();
      if (p % 2 == 0) req = 4'b1001;
      tick();
      req = 4'b1000;
      repeat (5) tick();
      checks++; if (grant !== exp_g[p]) $display("FAIL level_held%0d: got %b expected %b", p, grant, exp_g[p]); else passes++;
      tick();
    end
    req = '0;
  endtask

  task automatic test_live_data();
    do_reset();
    req = 4'b0010;
    tick();
    req = '0;
    repeat (12) tick();
    checks++; if (hex_all !== 16'h2222) $display("FAIL live_before: got %h expected 2222", hex_all); else passes++;
    data[31:16] = 16'hBEEF;
    tick();
    checks++; if (hex_all !== 16'hBEEF) $display("FAIL live_after: got %h expected beef", hex_all); else passes++;
    checks++; if (grant !== 4'b0010) $display("FAIL live_grant: got %b expected 0010", grant); else passes++;
    data[31:16] = 16'h2222;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    req = 4'b0100;
    tick();
    req = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++; if (grant !== 4'b0000) $display("FAIL rmid_grant: got %b expected 0000", grant); else passes++;
    checks++; if (active !== 1'b0) $display("FAIL rmid_active: got %b expected 0", active); else passes++;
    checks++; if (hold_busy !== 1'b0) $display("FAIL rmid_hb: got %b expected 0", hold_busy); else passes++;
    checks++; if (hex_all !== 16'h0000) $display("FAIL rmid_hex: got %h expected 0000", hex_all); else passes++;
    checks++; if (dp_out !== 4'b1111) $display("FAIL rmid_dp: got %b expected 1111", dp_out); else passes++;
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (grant !== 4'b0000) $display("FAIL rmid_pending_lost: got %b expected 0000", grant); else passes++;
  endtask

`ifdef DISP_PAGE_AUTO_SCROLL_EN
  task automatic test_auto_scroll();
    do_reset();
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    repeat (15) tick();
    checks++; if (grant !== 4'b1000) $display("FAIL scroll_before: got %b expected 1000", grant); else passes++;
    tick();
    checks++; if (grant !== 4'b0001) $display("FAIL scroll_advance: got %b expected 0001", grant); else passes++;
  endtask
`endif

  initial begin
    reset = 1'b1;
    req   = '0;
    data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    dp    = {4{4'b1011}};
    test_reset();
    test_single();
    test_simultaneous();
    test_hold_request();
    test_level();
    test_live_data();
    test_reset_mid();
`ifdef DISP_PAGE_AUTO_SCROLL_EN
    test_auto_scroll();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
